// File: rtl/handshake_controller.sv
// Request/acknowledge handshake sequencer for the inter-board link: drives the header
// transmitter, re-arms the header receiver, and retries on timeout before giving up.
module handshake_controller #(
   parameter int unsigned           HEAD_BITS      = 8,
   parameter logic [HEAD_BITS-1:0]  REQ_WORD       = 8'hA5,
   parameter logic [HEAD_BITS-1:0]  ACK_WORD       = 8'h5A,
   parameter int unsigned           TIMEOUT_CYCLES = 1024,
   parameter int unsigned           MAX_RETRIES    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 connect_req,
   input  logic                 send_done,
   output logic                 send_start,
   output logic [HEAD_BITS-1:0] tx_data,
   input  logic                 receive_done,
   input  logic [HEAD_BITS-1:0] rx_data,
   output logic                 receive_start,
   output logic                 connected,
   output logic                 failed,
   output logic [2:0]           hs_state
);

   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
   localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StSendReq   = 3'd1,
      StWaitAck   = 3'd2,
      StSendAck   = 3'd3,
      StConnected = 3'd4,
      StFailed    = 3'd5
   } state_e;

   state_e              state_q;
   logic [TimerW-1:0]   timer_q;
   logic [RetryW-1:0]   retry_q;
   logic                rx_valid;

   // A receive_done seen while re-arming is the stale previous header.
   assign rx_valid = receive_done && !receive_start;
   assign hs_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         retry_q       <= '0;
         send_start    <= 1'b0;
         receive_start <= 1'b0;
         connected     <= 1'b0;
         failed        <= 1'b0;
         tx_data       <= '0;
      end else begin
         send_start    <= 1'b0;
         receive_start <= 1'b0;
         if (!connect_req) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            connected <= 1'b0;
            failed    <= 1'b0;
            tx_data   <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_q    <= StSendReq;
                  retry_q    <= '0;
                  send_start <= 1'b1;
                  tx_data    <= REQ_WORD;
               end
               StSendReq: begin
                  if (send_done && !send_start) begin
                     state_q       <= StWaitAck;
                     timer_q       <= '0;
                     receive_start <= 1'b1;
                  end
               end
               StWaitAck: begin
                  if (rx_valid) begin
                     if (rx_data == ACK_WORD) begin
                        state_q   <= StConnected;
                        connected <= 1'b1;
                     end else if (rx_data == REQ_WORD) begin
                        state_q    <= StSendAck;
                        send_start <= 1'b1;
                        tx_data    <= ACK_WORD;
                     end else begin
                        // Junk header: re-arm and keep the timeout running.
                        receive_start <= 1'b1;
                        timer_q       <= (timer_q == TimerLast) ? '0 : timer_q + 1'b1;
                     end
                  end else if (timer_q == TimerLast) begin
                     if (retry_q < RetryMax) begin
                        retry_q    <= retry_q + 1'b1;
                        state_q    <= StSendReq;
                        send_start <= 1'b1;
                        tx_data    <= REQ_WORD;
                     end else begin
                        state_q <= StFailed;
                        failed  <= 1'b1;
                     end
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               StSendAck: begin
                  if (send_done && !send_start) begin
                     state_q   <= StConnected;
                     connected <= 1'b1;
                  end
               end
               StConnected, StFailed: ;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_handshake_controller.sv
// Self-checking bench for handshake_controller: a scripted peer (transmitter + receiver)
// with expected event cycles derived from the protocol timing rules.
module tb_handshake_controller;

   localparam int unsigned T  = 16;
   localparam int unsigned MR = 2;
   localparam logic [7:0]  REQ = 8'hA5;
   localparam logic [7:0]  ACK = 8'h5A;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       connect_req = 1'b0;
   logic       send_done = 1'b0;
   logic       send_start;
   logic [7:0] tx_data;
   logic       receive_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       receive_start;
   logic       connected;
   logic       failed;
   logic [2:0] hs_state;

   int tests = 0;
   int failures = 0;

   handshake_controller #(
      .HEAD_BITS(8), .REQ_WORD(REQ), .ACK_WORD(ACK), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
   ) dut (
      .clk(clk), .rst(rst), .connect_req(connect_req), .send_done(send_done),
      .send_start(send_start), .tx_data(tx_data), .receive_done(receive_done),
      .rx_data(rx_data), .receive_start(receive_start), .connected(connected),
      .failed(failed), .hs_state(hs_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One link session. n_to windows time out before the peer answers in window n_to at
   // offset r (REQ if resp_req, else ACK); g>0 places junk header gv at offset g of window 0.
   task automatic run_session(input int n_to, input bit resp_req, input int r, input int g,
                              input logic [7:0] gv, input int d, input int abort_at,
                              input bit rst_on_ack);
      int exp_ss, exp_rs, exp_conn, exp_fail, wins, stop_at;
      int sd_clr, sd_rise, rd_clr, rd_rise, rd_rise2;
      logic [7:0] exp_tx, rd_val2;
      bit rs_window, finished, do_rst;
      exp_ss = 1; exp_rs = -1; exp_conn = -1; exp_fail = -1; wins = 0; stop_at = abort_at;
      sd_clr = -1; sd_rise = -1; rd_clr = -1; rd_rise = -1; rd_rise2 = -1;
      exp_tx = REQ; rd_val2 = 8'h00; rs_window = 0; finished = 0; do_rst = 0;
      @(posedge clk); #1;
      connect_req = 1'b1;
      for (int c = 1; c <= 400 && !finished; c++) begin
         @(posedge clk); #1;
         tests++;
         if (send_start !== (c == exp_ss)) begin
            failures++;
            $display("FAIL send_start cycle %0d: got %b, expected %b", c, send_start, c == exp_ss);
         end
         tests++;
         if (receive_start !== (c == exp_rs)) begin
            failures++;
            $display("FAIL receive_start cycle %0d: got %b, expected %b", c, receive_start,
                     c == exp_rs);
         end
         tests++;
         if (connected !== (exp_conn >= 0 && c >= exp_conn)) begin
            failures++;
            $display("FAIL connected cycle %0d: got %b, expected %b", c, connected,
                     exp_conn >= 0 && c >= exp_conn);
         end
         tests++;
         if (failed !== (exp_fail >= 0 && c >= exp_fail)) begin
            failures++;
            $display("FAIL failed cycle %0d: got %b, expected %b", c, failed,
                     exp_fail >= 0 && c >= exp_fail);
         end
         if (c == exp_ss) begin
            tests++;
            if (tx_data !== exp_tx) begin
               failures++;
               $display("FAIL tx_data cycle %0d: got %h, expected %h", c, tx_data, exp_tx);
            end
            if (rst_on_ack && exp_tx == ACK) do_rst = 1;
            sd_clr = c + 1;
            sd_rise = c + d;
            if (exp_tx == REQ) begin
               exp_rs = c + d + 1;
               rs_window = 1;
            end else begin
               exp_conn = c + d + 1;
            end
            exp_ss = -1;
         end
         if (c == exp_rs) begin
            rd_clr = c + 1;
            exp_rs = -1;
            if (rs_window) begin
               rs_window = 0;
               if (wins == 0 && g > 0) begin
                  rd_rise = c + g;
                  exp_rs = c + g + 1;
               end
               if (wins < n_to) begin
                  if (wins < MR) begin
                     exp_ss = c + T;
                     exp_tx = REQ;
                  end else begin
                     exp_fail = c + T;
                  end
               end else begin
                  rd_rise2 = c + r;
                  rd_val2 = resp_req ? REQ : ACK;
                  if (resp_req) begin
                     exp_ss = c + r + 1;
                     exp_tx = ACK;
                  end else begin
                     exp_conn = c + r + 1;
                  end
               end
               wins++;
            end
         end
         // Peer drive for the next edge; done flags stay up through the start-pulse cycle.
         if (c == sd_clr) send_done = 1'b0;
         if (c == sd_rise) send_done = 1'b1;
         if (c == rd_clr) receive_done = 1'b0;
         if (c == rd_rise) begin
            receive_done = 1'b1;
            rx_data = gv;
         end
         if (c == rd_rise2) begin
            receive_done = 1'b1;
            rx_data = rd_val2;
         end
         if (!receive_done) rx_data = 8'($urandom);
         if (stop_at < 0 && ((exp_conn >= 0 && c == exp_conn + 2) ||
                             (exp_fail >= 0 && c == exp_fail + 2))) stop_at = c;
         if (do_rst) begin
            #2 rst = 1'b1;
            #1;
            tests++;
            if ({send_start, receive_start, connected, failed, tx_data} !== 12'h000) begin
               failures++;
               $display("FAIL async_reset: got ss=%b rs=%b conn=%b fail=%b tx=%h, expected all 0",
                        send_start, receive_start, connected, failed, tx_data);
            end
            #2;
            connect_req = 1'b0; send_done = 1'b0; receive_done = 1'b0;
            rst = 1'b0;
            finished = 1;
         end else if (c == stop_at) begin
            connect_req = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(posedge clk); #1;
               tests++;
               if ({send_start, receive_start, connected, failed, tx_data} !== 12'h000) begin
                  failures++;
                  $display("FAIL disconnect +%0d: got ss=%b rs=%b conn=%b fail=%b tx=%h, %s",
                           k + 1, send_start, receive_start, connected, failed, tx_data,
                           "expected all 0");
               end
            end
            finished = 1;
         end
      end
      tests++;
      if (!finished) begin
         failures++;
         $display("FAIL session_bound: got unfinished session, expected completion in 400 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      connect_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({send_start, receive_start, connected, failed, tx_data} !== 12'h000) begin
         failures++;
         $display("FAIL reset_values: got ss=%b rs=%b conn=%b fail=%b tx=%h, expected all 0",
                  send_start, receive_start, connected, failed, tx_data);
      end
      connect_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({send_start, connected, failed} !== 3'b000) begin
         failures++;
         $display("FAIL reset_holds: got ss=%b conn=%b fail=%b, expected 000",
                  send_start, connected, failed);
      end
      connect_req = 1'b0;
      #3 rst = 1'b0;
   endtask

   task automatic test_happy_path();
      run_session(0, 1'b0, 10, 0, 8'h33, 20, -1, 1'b0);
   endtask

   task automatic test_crossed_requests();
      run_session(0, 1'b1, 6, 0, 8'h33, 4, -1, 1'b0);
   endtask

   task automatic test_timeout_fail();
      run_session(3, 1'b0, 5, 0, 8'h33, 3, -1, 1'b0);
   endtask

   task automatic test_garbage_header();
      run_session(1, 1'b0, 8, 5, 8'h33, 3, -1, 1'b0);
   endtask

   task automatic test_ack_in_timeout_cycle();
      run_session(0, 1'b0, 15, 0, 8'h33, 2, -1, 1'b0);
      run_session(1, 1'b0, 15, 0, 8'h33, 2, -1, 1'b0);
   endtask

   // Abort during the second WAIT_ACK (cycle 26 with d=2), then a fresh session must
   // again allow the full three requests before failing.
   task automatic test_abort_and_retry_restart();
      run_session(3, 1'b0, 5, 0, 8'h33, 2, 26, 1'b0);
      run_session(3, 1'b0, 5, 0, 8'h33, 2, -1, 1'b0);
   endtask

   task automatic test_reset_in_send_ack();
      run_session(0, 1'b1, 4, 0, 8'h33, 3, -1, 1'b1);
      run_session(0, 1'b0, 3, 0, 8'h33, 2, -1, 1'b0);
   endtask

   task automatic test_random_sessions();
      for (int i = 0; i < 25; i++) begin
         int n_to, g, r, d;
         bit rq;
         logic [7:0] gv;
         n_to = $urandom_range(0, 3);
         rq = 1'($urandom);
         g = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 13) : 0;
         r = (n_to == 0 && g > 0) ? $urandom_range(g + 2, 15) : $urandom_range(1, 15);
         d = $urandom_range(2, 8);
         gv = 8'($urandom);
         while (gv == REQ || gv == ACK) gv = 8'($urandom);
         run_session(n_to, rq, r, g, gv, d, -1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_happy_path();
      test_crossed_requests();
      test_timeout_fail();
      test_garbage_header();
      test_ack_in_timeout_cycle();
      test_abort_and_retry_restart();
      test_reset_in_send_ack();
      test_random_sessions();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
